// File: rtl/ap_mem_pkg.sv
// Shared definitions for the memory-side responders: FSM encoding, address stride
// and the instruction field layout that fixes the instruction width.
package ap_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } isa_state_e;

  localparam int WORD_BYTES = 8;

  localparam int OPCODE_W   = 4;
  localparam int CAM_ADDR_W = 8;
  localparam int OPERAND2_W = 2;
  localparam int MEM_ADDR_W = 16;
  localparam int ISA_W      = OPCODE_W + CAM_ADDR_W + OPERAND2_W + MEM_ADDR_W;

  typedef struct packed {
    logic [OPCODE_W-1:0]   opcode;
    logic [CAM_ADDR_W-1:0] cam_addr;
    logic [OPERAND2_W-1:0] operand2;
    logic [MEM_ADDR_W-1:0] mem_addr;
  } isa_word_t;

endpackage

// File: rtl/isa_burst_splitter.sv
// Splits a long fetch into bursts of at most MAX_BURST beats; tracks how many beats
// have been requested so far and derives the next burst address and length.
module isa_burst_splitter
  import ap_mem_pkg::*;
#(
  parameter int ADDR_W       = 28,
  parameter int LEN_W        = 10,
  parameter int MAX_BURST    = 64,
  parameter int WORD_BYTES_P = WORD_BYTES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              advance,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  total_len,
  output logic [LEN_W-1:0]  chunk_len,
  output logic [ADDR_W-1:0] burst_addr,
  output logic              last_chunk
);

  logic [LEN_W-1:0] issued_q;
  logic [LEN_W-1:0] issued_d;
  logic [LEN_W-1:0] remaining;
  logic [LEN_W-1:0] issued_after;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BURST);

  always_comb begin
    remaining    = total_len - issued_q;
    chunk_len    = (remaining > MAX_LEN) ? MAX_LEN : remaining;
    issued_after = issued_q + chunk_len;
    last_chunk   = !(issued_after < total_len);
    // Offset is formed at full address width so the sum wraps instead of saturating.
    burst_addr   = base_addr + (ADDR_W'(issued_q) * ADDR_W'(WORD_BYTES_P));
  end

  always_comb begin
    issued_d = issued_q;
    if (clear) begin
      issued_d = '0;
    end else if (advance) begin
      issued_d = issued_after;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issued_q <= '0;
    end else begin
      issued_q <= issued_d;
    end
  end

endmodule

// File: rtl/isa_read_server.sv
// Serves instruction-cache fetch requests by issuing DDR burst reads and returning
// one instruction per beat with a running delivered count.
module isa_read_server
  import ap_mem_pkg::*;
#(
  parameter int DDR_ADDR_WIDTH = 28,
  parameter int DDR_DATA_WIDTH = 64,
  parameter int ISA_WIDTH      = ISA_W,
  parameter int LEN_WIDTH      = 10,
  parameter int MAX_BURST      = 64,
  parameter int WORD_BYTES_P   = WORD_BYTES
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ISA_read_req,
  input  logic [DDR_ADDR_WIDTH-1:0] ISA_read_addr,
  input  logic [LEN_WIDTH-1:0]      isa_read_len,
  output logic [ISA_WIDTH-1:0]      instruction_to_cache,
  output logic [LEN_WIDTH-1:0]      rd_cnt_isa,
  output logic                      rd_burst_data_valid,
  output logic                      busy,
  output logic                      ddr_rd_burst_req,
  output logic [DDR_ADDR_WIDTH-1:0] ddr_rd_burst_addr,
  output logic [LEN_WIDTH-1:0]      ddr_rd_burst_len,
  input  logic [DDR_DATA_WIDTH-1:0] ddr_rd_burst_data,
  input  logic                      ddr_rd_burst_data_valid,
  input  logic                      ddr_rd_burst_finish
);

  isa_state_e                state_q, state_d;
  logic [DDR_ADDR_WIDTH-1:0] base_q, base_d;
  logic [LEN_WIDTH-1:0]      len_q, len_d;
  logic [LEN_WIDTH-1:0]      rd_cnt_q, rd_cnt_d;
  logic [ISA_WIDTH-1:0]      instr_q, instr_d;
  logic                      valid_q, valid_d;
  logic                      ddr_req_q, ddr_req_d;
  logic [DDR_ADDR_WIDTH-1:0] ddr_addr_q, ddr_addr_d;
  logic [LEN_WIDTH-1:0]      ddr_len_q, ddr_len_d;
  logic                      abort_q, abort_d;

  logic                      split_clear;
  logic                      split_advance;
  logic [LEN_WIDTH-1:0]      split_chunk;
  logic [DDR_ADDR_WIDTH-1:0] split_addr;
  logic                      split_last;
  logic                      beat_drop;
  logic                      unused_data_hi;

  assign unused_data_hi = ^ddr_rd_burst_data[DDR_DATA_WIDTH-1:ISA_WIDTH];

  isa_burst_splitter #(
    .ADDR_W      (DDR_ADDR_WIDTH),
    .LEN_W       (LEN_WIDTH),
    .MAX_BURST   (MAX_BURST),
    .WORD_BYTES_P(WORD_BYTES_P)
  ) u_splitter (
    .clk       (clk),
    .rst       (rst),
    .clear     (split_clear),
    .advance   (split_advance),
    .base_addr (base_q),
    .total_len (len_q),
    .chunk_len (split_chunk),
    .burst_addr(split_addr),
    .last_chunk(split_last)
  );

  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    len_d         = len_q;
    rd_cnt_d      = rd_cnt_q;
    instr_d       = instr_q;
    valid_d       = 1'b0;
    ddr_req_d     = ddr_req_q;
    ddr_addr_d    = ddr_addr_q;
    ddr_len_d     = ddr_len_q;
    abort_d       = abort_q;
    split_clear   = 1'b0;
    split_advance = 1'b0;
    beat_drop     = abort_q || !ISA_read_req;

    case (state_q)
      ST_IDLE: begin
        if (ISA_read_req) begin
          base_d      = ISA_read_addr;
          len_d       = isa_read_len;
          rd_cnt_d    = '0;
          abort_d     = 1'b0;
          split_clear = 1'b1;
          state_d     = (isa_read_len == '0) ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ: begin
        ddr_req_d  = 1'b1;
        ddr_addr_d = split_addr;
        ddr_len_d  = split_chunk;
        if (!ISA_read_req) abort_d = 1'b1;
        state_d    = ST_DATA;
      end
      ST_DATA: begin
        if (!ISA_read_req) abort_d = 1'b1;
        // A beat in the finish cycle is counted before the finish transition.
        if (ddr_rd_burst_data_valid && !beat_drop && (rd_cnt_q < len_q)) begin
          instr_d  = ddr_rd_burst_data[ISA_WIDTH-1:0];
          rd_cnt_d = rd_cnt_q + LEN_WIDTH'(1);
          valid_d  = 1'b1;
        end
        if (ddr_rd_burst_finish) begin
          ddr_req_d = 1'b0;
          if (beat_drop) begin
            rd_cnt_d = '0;
            abort_d  = 1'b0;
            state_d  = ST_IDLE;
          end else begin
            split_advance = 1'b1;
            state_d       = split_last ? ST_DONE : ST_REQ;
          end
        end
      end
      ST_DONE: begin
        if (!ISA_read_req) begin
          rd_cnt_d = '0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      len_q      <= '0;
      rd_cnt_q   <= '0;
      instr_q    <= '0;
      valid_q    <= 1'b0;
      ddr_req_q  <= 1'b0;
      ddr_addr_q <= '0;
      ddr_len_q  <= '0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      rd_cnt_q   <= rd_cnt_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      ddr_req_q  <= ddr_req_d;
      ddr_addr_q <= ddr_addr_d;
      ddr_len_q  <= ddr_len_d;
      abort_q    <= abort_d;
    end
  end

  assign instruction_to_cache = instr_q;
  assign rd_cnt_isa           = rd_cnt_q;
  assign rd_burst_data_valid  = valid_q;
  assign busy                 = (state_q != ST_IDLE);
  assign ddr_rd_burst_req     = ddr_req_q;
  assign ddr_rd_burst_addr    = ddr_addr_q;
  assign ddr_rd_burst_len     = ddr_len_q;

endmodule

// File: tb/tb_isa_read_server.sv
// Directed bench for isa_read_server: the bench plays the DDR controller and the
// instruction cache, with expected values worked out from the request parameters.
module tb_isa_read_server;

  logic        clk = 1'b0;
  logic        rst;
  logic        ISA_read_req;
  logic [27:0] ISA_read_addr;
  logic [9:0]  isa_read_len;
  logic [29:0] instruction_to_cache;
  logic [9:0]  rd_cnt_isa;
  logic        rd_burst_data_valid;
  logic        busy;
  logic        ddr_rd_burst_req;
  logic [27:0] ddr_rd_burst_addr;
  logic [9:0]  ddr_rd_burst_len;
  logic [63:0] ddr_rd_burst_data;
  logic        ddr_rd_burst_data_valid;
  logic        ddr_rd_burst_finish;

  int          total = 0;
  int          bad = 0;
  int          exp_cnt = 0;
  logic [29:0] exp_instr = '0;
  int          seq = 1;

  always #5 clk = ~clk;

  isa_read_server dut (
    .clk                    (clk),
    .rst                    (rst),
    .ISA_read_req           (ISA_read_req),
    .ISA_read_addr          (ISA_read_addr),
    .isa_read_len           (isa_read_len),
    .instruction_to_cache   (instruction_to_cache),
    .rd_cnt_isa             (rd_cnt_isa),
    .rd_burst_data_valid    (rd_burst_data_valid),
    .busy                   (busy),
    .ddr_rd_burst_req       (ddr_rd_burst_req),
    .ddr_rd_burst_addr      (ddr_rd_burst_addr),
    .ddr_rd_burst_len       (ddr_rd_burst_len),
    .ddr_rd_burst_data      (ddr_rd_burst_data),
    .ddr_rd_burst_data_valid(ddr_rd_burst_data_valid),
    .ddr_rd_burst_finish    (ddr_rd_burst_finish)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] beat_word(input int n);
    logic [31:0] nn;
    nn = 32'(n);
    return {32'hA500_0000 | nn, 32'h4000_0000 ^ (nn * 32'h0101_0101 + 32'h1357)};
  endfunction

  task automatic start_req(input logic [27:0] addr, input logic [9:0] len);
    ISA_read_addr = addr;
    isa_read_len  = len;
    ISA_read_req  = 1'b1;
    exp_cnt       = 0;
  endtask

  // Waits for a burst request, checks it, then feeds nbeats beats.
  task automatic do_burst(input logic [27:0] eaddr, input int elen, input int nbeats,
                          input int req_len, input int drop_after, input bit send_finish);
    int n = 0;
    while (!ddr_rd_burst_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("burst_req_seen", 64'(ddr_rd_burst_req), 64'd1);
    chk("burst_addr", 64'(ddr_rd_burst_addr), 64'(eaddr));
    chk("burst_len", 64'(ddr_rd_burst_len), 64'(elen));
    for (int i = 0; i < nbeats; i++) begin
      logic [63:0] w;
      bit          dropped;
      bit          exp_v;
      chk("burst_req_held", 64'(ddr_rd_burst_req), 64'd1);
      if (i == drop_after) ISA_read_req = 1'b0;
      w = beat_word(seq);
      seq++;
      ddr_rd_burst_data       = w;
      ddr_rd_burst_data_valid = 1'b1;
      ddr_rd_burst_finish     = send_finish && (i == nbeats - 1);
      @(negedge clk);
      dropped = (drop_after >= 0) && (i >= drop_after);
      exp_v   = 1'b0;
      if (!dropped && exp_cnt < req_len) begin
        exp_cnt++;
        exp_v     = 1'b1;
        exp_instr = w[29:0];
      end
      if (dropped && send_finish && i == nbeats - 1) exp_cnt = 0;
      chk("beat_valid", 64'(rd_burst_data_valid), 64'(exp_v));
      chk("beat_cnt", 64'(rd_cnt_isa), 64'(exp_cnt));
      chk("beat_instr", 64'(instruction_to_cache), 64'(exp_instr));
    end
    ddr_rd_burst_data_valid = 1'b0;
    ddr_rd_burst_finish     = 1'b0;
    chk("burst_req_after", 64'(ddr_rd_burst_req), send_finish ? 64'd0 : 64'd1);
    $display("burst addr=%0h len=%0d beats=%0d cnt=%0d", eaddr, elen, nbeats, exp_cnt);
  endtask

  // Checks the DONE hold, then releases the request and checks the return to IDLE.
  task automatic finish_req(input int hold_cnt);
    repeat (2) @(negedge clk);
    chk("done_busy", 64'(busy), 64'd1);
    chk("done_cnt", 64'(rd_cnt_isa), 64'(hold_cnt));
    chk("done_valid", 64'(rd_burst_data_valid), 64'd0);
    chk("done_instr", 64'(instruction_to_cache), 64'(exp_instr));
    ISA_read_req = 1'b0;
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_cnt", 64'(rd_cnt_isa), 64'd0);
    $display("request released cnt_held=%0d", hold_cnt);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    ISA_read_req = 1'b0;
    ISA_read_addr = '0;
    isa_read_len = '0;
    ddr_rd_burst_data = '0;
    ddr_rd_burst_data_valid = 1'b0;
    ddr_rd_burst_finish = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cnt", 64'(rd_cnt_isa), 64'd0);
    chk("rst_valid", 64'(rd_burst_data_valid), 64'd0);
    chk("rst_ddr_req", 64'(ddr_rd_burst_req), 64'd0);
    chk("rst_instr", 64'(instruction_to_cache), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    $display("reset released");

    // Single short burst
    start_req(28'h100, 10'd5);
    do_burst(28'h100, 5, 5, 5, -1, 1'b1);
    finish_req(5);

    // Long request split into two full bursts
    start_req(28'h0, 10'd128);
    do_burst(28'h0, 64, 64, 128, -1, 1'b1);
    do_burst(28'h200, 64, 64, 128, -1, 1'b1);
    finish_req(128);

    // Split with a short tail and address wrap
    start_req(28'hFFF_FF00, 10'd70);
    do_burst(28'hFFF_FF00, 64, 64, 70, -1, 1'b1);
    do_burst(28'h000_0100, 6, 6, 70, -1, 1'b1);
    finish_req(70);

    // Zero-length request
    start_req(28'h80, 10'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("len0_no_ddr_req", 64'(ddr_rd_burst_req), 64'd0);
    end
    $display("zero length request");
    finish_req(0);

    // Request dropped after three beats of ten
    start_req(28'h400, 10'd10);
    do_burst(28'h400, 10, 10, 10, 3, 1'b1);
    chk("drop_busy", 64'(busy), 64'd0);
    chk("drop_cnt", 64'(rd_cnt_isa), 64'd0);
    @(negedge clk);

    // DDR over-delivers one beat
    start_req(28'h800, 10'd5);
    do_burst(28'h800, 5, 6, 5, -1, 1'b1);
    finish_req(5);

    // Reset in the middle of a burst, then a stray beat
    start_req(28'h40, 10'd5);
    do_burst(28'h40, 5, 2, 5, -1, 1'b0);
    rst = 1'b1;
    ISA_read_req = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_cnt", 64'(rd_cnt_isa), 64'd0);
    chk("midrst_valid", 64'(rd_burst_data_valid), 64'd0);
    chk("midrst_instr", 64'(instruction_to_cache), 64'd0);
    chk("midrst_ddr_req", 64'(ddr_rd_burst_req), 64'd0);
    chk("midrst_ddr_addr", 64'(ddr_rd_burst_addr), 64'd0);
    chk("midrst_ddr_len", 64'(ddr_rd_burst_len), 64'd0);
    rst = 1'b0;
    ddr_rd_burst_data = beat_word(999);
    ddr_rd_burst_data_valid = 1'b1;
    @(negedge clk);
    ddr_rd_burst_data_valid = 1'b0;
    chk("stray_valid", 64'(rd_burst_data_valid), 64'd0);
    chk("stray_cnt", 64'(rd_cnt_isa), 64'd0);
    chk("stray_busy", 64'(busy), 64'd0);
    $display("mid-burst reset and stray beat");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/isa_read_server.md
Name: isa_read_server

Overview:
- Memory-side responder for the instruction cache's ISA fetch protocol.
- Accepts a level-held fetch request (start address, length in instructions) from the instruction cache. Issues one or more burst reads to the DDR controller. Returns one instruction per DDR beat with a running delivered-count.
- Sits between the instruction cache and the DDR read-burst port. Owns chunking of long requests and holds its result until the cache releases the request.

Parameters:
- DDR_ADDR_WIDTH, 28, DDR byte-address width.
- DDR_DATA_WIDTH, 64, DDR beat width.
- ISA_WIDTH, 30, instruction width; the low ISA_WIDTH bits of each beat are used.
- LEN_WIDTH, 10, width of lengths and counts.
- MAX_BURST, 64, maximum DDR beats per burst.
- WORD_BYTES, 8, address stride per instruction.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- ISA_read_req  in  1  fetch request, level; held by the cache until rd_cnt_isa >= isa_read_len
- ISA_read_addr  in  DDR_ADDR_WIDTH  start byte address, sampled at request accept
- isa_read_len  in  LEN_WIDTH  instructions to fetch, sampled at request accept
- instruction_to_cache  out  ISA_WIDTH  most recent instruction delivered
- rd_cnt_isa  out  LEN_WIDTH  instructions delivered so far in this request
- rd_burst_data_valid  out  1  one-cycle pulse per delivered instruction
- busy  out  1  high whenever not in IDLE
- ddr_rd_burst_req  out  1  DDR burst read request
- ddr_rd_burst_addr  out  DDR_ADDR_WIDTH  burst start byte address
- ddr_rd_burst_len  out  LEN_WIDTH  burst length in beats
- ddr_rd_burst_data  in  DDR_DATA_WIDTH  DDR read data
- ddr_rd_burst_data_valid  in  1  DDR beat valid
- ddr_rd_burst_finish  in  1  one-cycle pulse at end of DDR burst

Behaviour:
- Reset (rst=1 at a clk edge):
  - All outputs go to 0; state goes to IDLE; internal counters clear.
  - Reset mid-burst abandons the transfer immediately. Later DDR beats are ignored until a new request is accepted.
- IDLE:
  - When ISA_read_req=1, latch addr, len and issued=0 (rd_cnt_isa is already 0).
  - If len=0, go to DONE; otherwise go to REQ.
- REQ:
  - chunk = min(MAX_BURST, len - issued).
  - ddr_rd_burst_addr = base + issued*WORD_BYTES; ddr_rd_burst_len = chunk; ddr_rd_burst_req=1.
  - Go to DATA.
- DATA:
  - ddr_rd_burst_req stays 1 until ddr_rd_burst_finish, then drops the next cycle.
  - Each DDR valid beat while rd_cnt_isa < len:
    - instruction_to_cache <= data[ISA_WIDTH-1:0]
    - rd_cnt_isa <= rd_cnt_isa+1
    - rd_burst_data_valid <= 1 for one cycle
    - Latency is exactly 1 cycle from DDR beat to outputs.
  - Beats arriving when rd_cnt_isa = len are dropped.
  - On finish: issued += chunk. If issued < len, go to REQ; otherwise go to DONE.
  - If finish arrives before chunk beats, the missing count is not re-fetched; issued still advances by chunk.
- Output holding:
  - instruction_to_cache holds its value between beats; the cache writes entry rd_cnt_isa-1 one cycle after the valid pulse.
  - rd_cnt_isa never decrements during a request.
- DONE:
  - Hold rd_cnt_isa (=len) and the last instruction until ISA_read_req=0.
  - Then clear rd_cnt_isa to 0 and go to IDLE.
  - A re-asserted request is accepted no earlier than the cycle after IDLE is entered.
- Request dropped in REQ or DATA:
  - The current DDR burst runs to ddr_rd_burst_finish; it is not aborted.
  - Its beats are discarded: no valid pulses, no count change.
  - After finish, go straight to IDLE with rd_cnt_isa cleared.
- Address arithmetic:
  - Computed in DDR_ADDR_WIDTH bits; wraps modulo 2^DDR_ADDR_WIDTH with no error.
  - len is treated as unsigned.
- Simultaneous events:
  - A DDR beat and ddr_rd_burst_finish in the same cycle: the beat counts first, then the finish transition is taken.
- State encoding: IDLE=0, REQ=1, DATA=2, DONE=3.

Decomposition:
- Shared package ap_mem_pkg:
  - State encodings.
  - WORD_BYTES.
  - The ISA field widths (opcode 4, CAM address 8, operand-2 2, memory address 16; ISA_WIDTH derived from these).
- One natural sub-module, isa_burst_splitter:
  - Computes chunk and next address from base, len and issued.
  - Purely combinational, with a registered issued counter.
  - Reusable by a future data-read responder.

Test Plan:
- len=5, addr=0x100, MAX_BURST=64:
  - One burst, addr 0x100, len 5.
  - Five valid pulses; rd_cnt_isa steps 1..5 with matching instructions.
  - Holds 5 until req drops, then 0 in IDLE.
- len=128, MAX_BURST=64, addr=0:
  - Two bursts: addr 0/len 64, then addr 0x200/len 64.
  - rd_cnt_isa reaches 128 with no gap in count order.
- len=0:
  - No DDR request; DONE entered.
  - rd_cnt_isa stays 0; IDLE after req drops.
- req dropped after 3 of 10 beats:
  - ddr_rd_burst_req held to finish.
  - Beats 4..10 produce no pulses; rd_cnt_isa=0 afterwards.
- rst=1 asserted mid-DATA:
  - Next cycle all outputs are 0 and state is IDLE.
  - A following stray DDR beat causes no pulse.
- DDR delivers 6 beats for len=5:
  - Sixth beat ignored; rd_cnt_isa stays 5; instruction_to_cache keeps beat 5 data.
